// File: rtl/uart_ram_sequencer_pkg.sv
// uart_ram_sequencer_pkg: shared state encoding, command bytes and widths for the host RAM sequencer
package uart_ram_sequencer_pkg;
    localparam int DEF_ADDR_W = 16;
    localparam logic [7:0] DEF_CMD_LOAD = 8'h4C;
    localparam logic [7:0] DEF_CMD_READ = 8'h52;
    localparam logic [7:0] DEF_CMD_GO   = 8'h47;
    typedef enum logic [3:0] {
        IDLE, H_AH, H_AL, H_LH, H_LL, LOAD, RD_ADDR, RD_WAIT, RD_TX, RUN
    } state_t;
endpackage

// File: rtl/uart_ram_sequencer_ctr.sv
// seq_addr_len_ctr: header-loadable wrapping address counter and length down-counter
module seq_addr_len_ctr #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_addr,
    input  logic              shift_len,
    input  logic              step,
    input  logic [7:0]        byte_in,
    output logic [ADDR_W-1:0] addr,
    output logic              len_last,
    output logic              len_load_zero
);
    logic [ADDR_W-1:0] len;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr <= '0;
            len  <= '0;
        end else begin
            if (shift_addr) addr <= {addr[ADDR_W-9:0], byte_in};
            else if (step) addr <= addr + 1'b1;
            if (shift_len) len <= {len[ADDR_W-9:0], byte_in};
            else if (step) len <= len - 1'b1;
        end
    end
    // len_load_zero looks at the length as it will be once the byte being shifted lands
    assign len_last      = len == ADDR_W'(1);
    assign len_load_zero = {len[ADDR_W-9:0], byte_in} == '0;
endmodule

// File: rtl/uart_ram_sequencer.sv
// uart_ram_sequencer: host command decoder owning the shared RAM for load, readback and CPU run
module uart_ram_sequencer
    import uart_ram_sequencer_pkg::*;
#(
    parameter int         ADDR_W      = DEF_ADDR_W,
    parameter logic [7:0] CMD_LOAD    = DEF_CMD_LOAD,
    parameter logic [7:0] CMD_READ    = DEF_CMD_READ,
    parameter logic [7:0] CMD_GO      = DEF_CMD_GO,
    parameter int         RUN_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done,
    input  logic [7:0]        rx_byte,
    output logic              tx_start,
    input  logic              tx_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_write,
    output logic              sel,
    output logic              reset_cpu,
    input  logic              cpu_finish,
    output logic              busy,
    output logic              err
);
    state_t      state, state_n;
    logic        is_load, err_n, shift_addr, shift_len, step, len_last, len_load_zero;
    logic [31:0] cnt;
    wire cmd_ok  = rx_byte == CMD_LOAD || rx_byte == CMD_READ || rx_byte == CMD_GO;
    wire timeout = RUN_TIMEOUT != 0 && cnt == 32'(RUN_TIMEOUT - 1);
    seq_addr_len_ctr #(.ADDR_W(ADDR_W)) u_ctr (
        .clk(clk), .reset(reset), .shift_addr(shift_addr), .shift_len(shift_len),
        .step(step), .byte_in(rx_byte), .addr(ram_addr), .len_last(len_last),
        .len_load_zero(len_load_zero)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            is_load   <= 1'b0;
            err       <= 1'b0;
            tx_start  <= 1'b0;
            sel       <= 1'b1;
            reset_cpu <= 1'b1;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            err       <= err_n;
            is_load   <= (state == IDLE && rx_done) ? rx_byte == CMD_LOAD : is_load;
            tx_start  <= state == RD_WAIT;
            sel       <= !(state == RUN && state_n == RUN);
            reset_cpu <= !(state == RUN && state_n == RUN);
            cnt       <= state == RUN ? cnt + 1'b1 : '0;
        end
    end
    always_comb begin
        state_n    = state;
        err_n      = err;
        shift_addr = 1'b0;
        shift_len  = 1'b0;
        step       = 1'b0;
        ram_write  = 1'b0;
        case (state)
            IDLE: if (rx_done) begin
                err_n   = !cmd_ok;
                state_n = !cmd_ok ? IDLE : rx_byte == CMD_GO ? RUN : H_AH;
            end
            H_AH, H_AL: if (rx_done) begin
                shift_addr = 1'b1;
                state_n    = state == H_AH ? H_AL : H_LH;
            end
            H_LH: if (rx_done) begin
                shift_len = 1'b1;
                state_n   = H_LL;
            end
            H_LL: if (rx_done) begin
                shift_len = 1'b1;
                state_n   = len_load_zero ? IDLE : is_load ? LOAD : RD_ADDR;
            end
            LOAD: if (rx_done) begin
                ram_write = 1'b1;
                step      = 1'b1;
                state_n   = len_last ? IDLE : LOAD;
            end
            RD_ADDR, RD_WAIT: begin
                err_n   = err | rx_done;
                state_n = state == RD_ADDR ? RD_WAIT : RD_TX;
            end
            RD_TX: begin
                err_n = err | rx_done;
                if (tx_done) begin
                    step    = 1'b1;
                    state_n = len_last ? IDLE : RD_ADDR;
                end
            end
            RUN: begin
                err_n   = err | rx_done | (timeout && !cpu_finish);
                state_n = (cpu_finish || timeout) ? IDLE : RUN;
            end
            default: state_n = IDLE;
        endcase
    end
    assign busy = state != IDLE;
endmodule
